// File: rtl/log_seq_ctrl.sv
// rtl/log_seq_ctrl.sv - logging address sequencer with req/ack memory writes
module log_seq_ctrl #(
  parameter int ADR_W = 24,
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_strobe,
  input  logic [ADR_W-1:0] start_adr,
  input  logic [ADR_W-1:0] stop_adr,
  input  logic [23:0]      status,
  input  logic             sample_valid,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [ADR_W-1:0] mem_adr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       wrap_cnt,
  output logic [OVR_W-1:0] ovr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WAIT_SMP, S_REQ, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic             cmd_q, cmd_d;
  logic [ADR_W-1:0] cur_adr_q, cur_adr_d;
  logic             cont_q, cont_d;
  logic             pend_abort_q, pend_abort_d;
  logic             mem_req_q, mem_req_d;
  logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       wrap_q, wrap_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  logic abort_cmd;
  logic run_cmd;
  logic unused_status;

  // Only RUN, CONT and ABORT carry meaning; the rest of the word is don't-care.
  assign unused_status = ^status[23:3];
  assign abort_cmd     = cmd_q & status[2];
  assign run_cmd       = cmd_q & ~status[2] & status[0];

  // Next-state, address walk, handshake and counter updates.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_strobe;
    cur_adr_d    = cur_adr_q;
    cont_d       = cont_q;
    pend_abort_d = pend_abort_q;
    mem_req_d    = mem_req_q;
    mem_adr_d    = mem_adr_q;
    done_d       = done_q;
    err_d        = err_q;
    wrap_d       = wrap_q;
    ovr_d        = ovr_q;

    // Samples arriving while a write is still in flight are dropped and counted.
    if ((state_q == S_REQ || state_q == S_NEXT) && sample_valid && !(&ovr_q)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (run_cmd) begin
          state_d = S_CHECK;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wrap_d  = '0;
          ovr_d   = '0;
        end
      end
      S_CHECK: begin
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (start_adr > stop_adr) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cur_adr_d = start_adr;
          cont_d    = status[1];
          state_d   = S_WAIT_SMP;
        end
      end
      S_WAIT_SMP: begin
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (sample_valid) begin
          mem_adr_d = cur_adr_q;
          mem_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // An abort here must not cut the handshake short; remember it instead.
        if (abort_cmd) begin
          pend_abort_d = 1'b1;
        end
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          pend_abort_d = 1'b0;
          state_d      = (pend_abort_q || abort_cmd) ? S_IDLE : S_NEXT;
        end
      end
      S_NEXT: begin
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (cur_adr_q == stop_adr) begin
          if (cont_q) begin
            cur_adr_d = start_adr;
            wrap_d    = (&wrap_q) ? wrap_q : wrap_q + 8'd1;
            state_d   = S_WAIT_SMP;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          cur_adr_d = cur_adr_q + ADR_W'(1);
          state_d   = S_WAIT_SMP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= 1'b0;
      cur_adr_q    <= '0;
      cont_q       <= 1'b0;
      pend_abort_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_adr_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wrap_q       <= '0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cur_adr_q    <= cur_adr_d;
      cont_q       <= cont_d;
      pend_abort_q <= pend_abort_d;
      mem_req_q    <= mem_req_d;
      mem_adr_q    <= mem_adr_d;
      done_q       <= done_d;
      err_q        <= err_d;
      wrap_q       <= wrap_d;
      ovr_q        <= ovr_d;
    end
  end

  assign busy     = (state_q == S_CHECK) || (state_q == S_WAIT_SMP) ||
                    (state_q == S_REQ)   || (state_q == S_NEXT);
  assign mem_req  = mem_req_q;
  assign mem_adr  = mem_adr_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wrap_cnt = wrap_q;
  assign ovr_cnt  = ovr_q;

endmodule

// File: tb/tb_log_seq_ctrl.sv
// tb/tb_log_seq_ctrl.sv - self-checking bench for log_seq_ctrl
module tb_log_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_strobe = 1'b0;
  logic        sample_valid = 1'b0;
  logic        mem_ack = 1'b0;
  logic [23:0] start_adr = '0;
  logic [23:0] stop_adr = '0;
  logic [23:0] status = '0;
  logic        mem_req, busy, done, err;
  logic [23:0] mem_adr;
  logic [7:0]  wrap_cnt, ovr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  log_seq_ctrl #(.ADR_W(24), .OVR_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_strobe(cmd_strobe),
    .start_adr(start_adr), .stop_adr(stop_adr), .status(status),
    .sample_valid(sample_valid), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_adr(mem_adr), .busy(busy), .done(done),
    .err(err), .wrap_cnt(wrap_cnt), .ovr_cnt(ovr_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a run is "n writes completed"; the address of write n is
  // start + n mod len, wraps are n / len, and a plain run ends when n == len.
  int          ph;       // 0 halted, 1 checking, 2 awaiting sample, 3 writing, 4 after write
  bit          m_live = 1'b0;
  bit          m_cmd, m_pend, m_cont;
  int          n, len;
  logic [23:0] m_start;
  logic [23:0] e_adr;
  bit          e_req, e_done, e_err;
  int          e_wrap, e_ovr;

  always @(posedge clk) begin
    bit c, ab, rn;
    if (!reset) begin
      ph = 0; m_cmd = 0; m_pend = 0; e_req = 0; e_adr = '0;
      e_done = 0; e_err = 0; e_wrap = 0; e_ovr = 0; m_live = 1;
    end else begin
      c  = m_cmd;
      ab = c && status[2];
      rn = c && !status[2] && status[0];
      if ((ph == 3 || ph == 4) && sample_valid && e_ovr < 255) e_ovr++;
      case (ph)
        0: if (rn) begin ph = 1; e_done = 0; e_err = 0; e_wrap = 0; e_ovr = 0; end
        1: begin
          if (ab) ph = 0;
          else if (start_adr > stop_adr) begin e_err = 1; ph = 0; end
          else begin
            m_start = start_adr; m_cont = status[1]; n = 0;
            len = int'(stop_adr - start_adr) + 1; ph = 2;
          end
        end
        2: begin
          if (ab) ph = 0;
          else if (sample_valid) begin e_adr = m_start + 24'(n % len); e_req = 1; ph = 3; end
        end
        3: begin
          if (ab) m_pend = 1;
          if (mem_ack) begin e_req = 0; n++; ph = m_pend ? 0 : 4; m_pend = 0; end
        end
        4: begin
          if (ab) ph = 0;
          else if (m_cont) begin
            if (n % len == 0) e_wrap = (n / len > 255) ? 255 : n / len;
            ph = 2;
          end else if (n == len) begin e_done = 1; ph = 0; end
          else ph = 2;
        end
        default: ph = 0;
      endcase
      m_cmd = cmd_strobe;
    end
  end

  // Per-cycle compare, handshake log, and memory-writer ack responder.
  bit          prev_req = 1'b0;
  logic [23:0] prev_adr = '0;
  int          age = 0;
  int          ack_lat = 1;
  logic [23:0] hs_q[$];

  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_mem_req", mem_req, e_req);
      chk("cyc_mem_adr", mem_adr, e_adr);
      chk("cyc_busy", busy, (ph >= 1 && ph <= 4));
      chk("cyc_done", done, e_done);
      chk("cyc_err", err, e_err);
      chk("cyc_wrap", wrap_cnt, e_wrap);
      chk("cyc_ovr", ovr_cnt, e_ovr);
    end
    if (prev_req && mem_ack) hs_q.push_back(prev_adr);
    prev_req = (mem_req === 1'b1);
    prev_adr = mem_adr;
    if (mem_req === 1'b1) begin
      age++;
      mem_ack = (age > ack_lat);
    end else begin
      age = 0;
      mem_ack = 1'b0;
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Strobe first; the receiver updates its registers on the edge ending the strobe.
  task automatic send(input logic [23:0] s, input logic [23:0] p, input logic [23:0] st);
    @(negedge clk) cmd_strobe = 1'b1;
    @(negedge clk) begin
      cmd_strobe = 1'b0; start_adr = s; stop_adr = p; status = st;
    end
  endtask

  task automatic pulse();
    @(negedge clk) sample_valid = 1'b1;
    @(negedge clk) sample_valid = 1'b0;
  endtask

  task automatic check_writes(input string name, input logic [23:0] e[$]);
    logic [23:0] got;
    chk({name, "_count"}, hs_q.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      got = (i < hs_q.size()) ? hs_q[i] : 24'hxxxxxx;
      chk({name, "_adr"}, got, e[i]);
    end
  endtask

  initial begin
    cyc(3);
    reset = 1'b1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wrap", wrap_cnt, 0);
    chk("rst_ovr", ovr_cnt, 0);

    // Plain run over four addresses.
    hs_q.delete(); ack_lat = 1;
    send(24'h10, 24'h13, 24'h1); cyc(2);
    repeat (4) begin pulse(); cyc(3); end
    cyc(3);
    check_writes("t1", '{24'h10, 24'h11, 24'h12, 24'h13});
    chk("t1_done", done, 1);
    chk("t1_ovr", ovr_cnt, 0);
    chk("t1_busy", busy, 0);

    // start > stop reports err at T+3, then a valid command clears it.
    hs_q.delete();
    send(24'h20, 24'h1F, 24'h1); cyc(2);
    chk("t2_err_t3", err, 1);
    chk("t2_done_cleared", done, 0);
    cyc(2);
    chk("t2_busy", busy, 0);
    chk("t2_nowrite", hs_q.size(), 0);
    send(24'h30, 24'h30, 24'h1); cyc(2);
    chk("t2_err_clear", err, 0);
    chk("t2_busy_run", busy, 1);
    pulse(); cyc(4);
    chk("t2_done", done, 1);
    check_writes("t2", '{24'h30});

    // Single-address wrap mode.
    hs_q.delete();
    send(24'hFF, 24'hFF, 24'h3); cyc(2);
    repeat (4) begin pulse(); cyc(3); end
    cyc(2);
    check_writes("t3", '{24'hFF, 24'hFF, 24'hFF, 24'hFF});
    chk("t3_wrap", wrap_cnt, 4);
    chk("t3_done", done, 0);
    chk("t3_busy", busy, 1);
    send(24'hFF, 24'hFF, 24'h4); cyc(2);
    chk("t3_abort_idle", busy, 0);
    chk("t3_wrap_kept", wrap_cnt, 4);

    // Slow ack with overrun samples during the request.
    hs_q.delete(); ack_lat = 10;
    send(24'h100, 24'h101, 24'h1); cyc(2);
    pulse();
    pulse(); cyc(1); pulse(); cyc(1); pulse();
    chk("t4_req_held", mem_req, 1);
    chk("t4_adr_held", mem_adr, 24'h100);
    cyc(8);
    chk("t4_ovr", ovr_cnt, 3);
    pulse(); cyc(15);
    chk("t4_done", done, 1);
    chk("t4_ovr_end", ovr_cnt, 3);
    check_writes("t4", '{24'h100, 24'h101});

    // Abort while a request is outstanding.
    hs_q.delete(); ack_lat = 8;
    send(24'h200, 24'h203, 24'h1); cyc(2);
    pulse();
    send(24'h200, 24'h203, 24'h4);
    chk("t5_req_kept", mem_req, 1);
    cyc(12);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_req", mem_req, 0);
    chk("t5_adr", mem_adr, 24'h200);
    check_writes("t5", '{24'h200});

    // Reset in the middle of a handshake, then a fresh run.
    hs_q.delete(); ack_lat = 1000;
    send(24'h300, 24'h301, 24'h1); cyc(2);
    pulse(); cyc(2);
    chk("t6_req_before", mem_req, 1);
    reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    chk("t6_req", mem_req, 0);
    chk("t6_adr", mem_adr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_err", err, 0);
    chk("t6_wrap", wrap_cnt, 0);
    chk("t6_ovr", ovr_cnt, 0);
    hs_q.delete(); ack_lat = 0;
    send(24'h300, 24'h300, 24'h1); cyc(2);
    pulse(); cyc(4);
    chk("t6_done_after", done, 1);
    check_writes("t6", '{24'h300});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/log_seq_ctrl.md
# log_seq_ctrl

Sequencer for the logging datapath. It takes the command registers written by the serial command receiver (start address, stop address, status word, one-cycle packet-done strobe) and walks a 24-bit memory write address from start to stop, one address per incoming sample. Each write is issued to the memory interface through a req/ack handshake. The block sits between the command receiver, the sample source and the memory writer, and reports progress, completion, errors and sample overruns.

## Interface
Parameters:
- ADR_W, 24, address width; matches the command receiver's 24-bit fields.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk.
- cmd_strobe  in  1  one-cycle pulse from the command receiver's pkt_done.
- start_adr  in  ADR_W  first write address; held stable by the receiver.
- stop_adr  in  ADR_W  last write address, inclusive.
- status  in  24  command word: bit0 RUN, bit1 CONT (wrap mode), bit2 ABORT; bits 23:3 ignored.
- sample_valid  in  1  one-cycle pulse: a new sample is ready for writing.
- mem_ack  in  1  memory writer accepted the current request.
- mem_req  out  1  write request; held until mem_ack.
- mem_adr  out  ADR_W  write address; stable while mem_req=1.
- busy  out  1  high in CHECK, WAIT_SMP, REQ, NEXT.
- done  out  1  level; run finished normally.
- err  out  1  level; last command had start_adr > stop_adr.
- wrap_cnt  out  8  number of CONT wraps, saturates at 255.
- ovr_cnt  out  OVR_W  samples lost, saturates at all-ones.

## Operation
- The command receiver updates its address and status registers on the same edge that ends the pkt_done cycle. For this reason cmd_strobe is registered once (cmd_d), and the FSM acts only on cmd_d.
- States: IDLE, CHECK, WAIT_SMP, REQ, NEXT, DONE, ERR.
- IDLE, DONE, ERR: cmd_d=1 with ABORT=0 and RUN=1 -> CHECK. The transition clears done, err, wrap_cnt and ovr_cnt. Any other command leaves the state unchanged.
- CHECK: if start_adr > stop_adr (unsigned), set err=1 and go to ERR. Otherwise load cur_adr=start_adr and the CONT flag, then go to WAIT_SMP.
- WAIT_SMP: sample_valid=1 -> mem_adr=cur_adr, mem_req=1, go to REQ.
- REQ: hold mem_req and mem_adr. mem_ack=1 -> mem_req=0, go to NEXT.
- NEXT: if cur_adr==stop_adr:
  - CONT=1: cur_adr=start_adr, wrap_cnt+1 (saturating), go to WAIT_SMP.
  - CONT=0: done=1, go to DONE.
  - Otherwise: cur_adr+1, go to WAIT_SMP.
- start_adr==stop_adr is legal: exactly one write per pass.
- Abort: cmd_d=1 with ABORT=1 in CHECK, WAIT_SMP or NEXT -> IDLE immediately. In REQ, a pending-abort flag is set; the handshake completes on mem_ack, then the FSM goes to IDLE, not NEXT. mem_req is never withdrawn before mem_ack. Abort does not set done.
- A non-abort command received while busy is ignored. No restart mid-run.
- Overrun: sample_valid=1 while in REQ or NEXT -> ovr_cnt+1 (saturating); the sample is dropped. sample_valid in IDLE, DONE, ERR or CHECK is ignored and not counted.
- Address arithmetic: ADR_W bits, unsigned. cur_adr never exceeds stop_adr, so no overflow occurs.

## Timing
- Reset (reset=0 at an edge): state IDLE, cmd_d=0, mem_req=0, mem_adr=0, busy=0, done=0, err=0, wrap_cnt=0, ovr_cnt=0, pending abort=0. Reset mid-handshake drops mem_req on that edge.
- cmd_strobe in cycle T -> cmd_d in T+1 -> CHECK in T+2 -> WAIT_SMP (or ERR with err=1) from T+3.
- sample_valid in a WAIT_SMP cycle -> mem_req=1 the following cycle.
- mem_ack may arrive in the first mem_req cycle. The minimum per-sample loop is 3 cycles: WAIT_SMP, REQ, NEXT.
- done asserts the cycle after the NEXT that handled the final address.
- cmd_d and sample_valid in the same cycle: the command is handled per state, and the sample is handled per state as defined above.

## Test plan
- start=0x000010, stop=0x000013, status=0x000001, sample_valid every 5 cycles, mem_ack one cycle after each req -> writes to 0x10,0x11,0x12,0x13; done=1; ovr_cnt=0; busy=0.
- start=0x000020, stop=0x00001F, RUN -> err=1 at T+3; no mem_req; a following valid command clears err.
- start=stop=0x0000FF, status=0x000003, 4 samples -> four writes to 0xFF; wrap_cnt=4; done stays 0.
- mem_ack held low for 10 cycles with sample_valid pulsed 3 times during REQ -> mem_req and mem_adr stable throughout; ovr_cnt=3; no lost handshake.
- ABORT (status=0x000004) received in REQ -> mem_req held until mem_ack; then IDLE; done=0; mem_adr not advanced.
- reset=0 asserted while mem_req=1 -> all outputs zero the next cycle; a new command works normally afterwards.
